// File: rtl/inst_queue_pkg.sv
// Shared constants for the instruction queue between fetch and decode.
package inst_queue_pkg;

    localparam int IQ_ADDR_W = 4;
    localparam int DEPTH     = 1 << IQ_ADDR_W;
    localparam int INST_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int ENTRY_W   = INST_W + ADDR_W;

    localparam logic IQ_EMPTY = 1'b1;
    localparam logic ENABLE   = 1'b1;

    localparam logic [IQ_ADDR_W:0]   CNT_DEPTH = (IQ_ADDR_W + 1)'(DEPTH);
    localparam logic [IQ_ADDR_W:0]   CNT_ONE   = (IQ_ADDR_W + 1)'(1);
    localparam logic [IQ_ADDR_W-1:0] PTR_ONE   = IQ_ADDR_W'(1);

    // Pointers wrap modulo DEPTH simply by overflowing their width.
    function automatic logic [IQ_ADDR_W-1:0] ptrInc(input logic [IQ_ADDR_W-1:0] p);
        return p + PTR_ONE;
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side and decode-side handshake of the instruction queue, plus flush.
interface inst_queue_if;
    import inst_queue_pkg::*;

    logic              IF_valid;
    logic [INST_W-1:0] IF_inst;
    logic [ADDR_W-1:0] IF_pc;
    logic              IF_queue_is_full;
    logic              ID_enable;
    logic              ID_queue_is_empty;
    logic [INST_W-1:0] ID_inst;
    logic [ADDR_W-1:0] ID_pc;
    logic              ROB_clear;

    // Master drives fetch data, pop requests and flush.
    modport master (
        output IF_valid, IF_inst, IF_pc, ID_enable, ROB_clear,
        input  IF_queue_is_full, ID_queue_is_empty, ID_inst, ID_pc
    );

    // Slave is the queue itself.
    modport slave (
        input  IF_valid, IF_inst, IF_pc, ID_enable, ROB_clear,
        output IF_queue_is_full, ID_queue_is_empty, ID_inst, ID_pc
    );

endinterface

// File: rtl/inst_queue_storage.sv
// Register array holding {inst, pc} entries: one synchronous write port,
// one asynchronous read port so the head is visible without a cycle of delay.
module iq_storage
    import inst_queue_pkg::*;
(
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [IQ_ADDR_W-1:0] waddr_i,
    input  logic [ENTRY_W-1:0]   wdata_i,
    input  logic [IQ_ADDR_W-1:0] raddr_i,
    output logic [ENTRY_W-1:0]   rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Write the entry at the tail slot when the control logic commits a push.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_queue.sv
// Circular FIFO between instruction fetch and decode. The head entry is shown
// combinationally to decode; a ROB clear empties the queue in one cycle.
module inst_queue
    import inst_queue_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    inst_queue_if.slave iq
);

    logic [IQ_ADDR_W-1:0] head_q, head_d;
    logic [IQ_ADDR_W-1:0] tail_q, tail_d;
    logic [IQ_ADDR_W:0]   count_q, count_d;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 memWe;
    logic [ENTRY_W-1:0]   headEntry;

    // Full/empty come straight from the registered count, so fetch and decode
    // can react combinationally without creating a loop.
    assign full  = (count_q == CNT_DEPTH);
    assign empty = (count_q == '0);
    assign push  = iq.IF_valid && !full;
    assign pop   = iq.ID_enable && !empty;

    // The memory only takes a write when the push really commits this edge.
    assign memWe = !rst && rdy && !iq.ROB_clear && push;

    iq_storage u_storage (
        .clk     (clk),
        .we_i    (memWe),
        .waddr_i (tail_q),
        .wdata_i ({iq.IF_inst, iq.IF_pc}),
        .raddr_i (head_q),
        .rdata_o (headEntry)
    );

    // Next pointers and count: a flush overrides any push/pop this cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (iq.ROB_clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = ptrInc(tail_q);
            end
            if (pop) begin
                head_d = ptrInc(head_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/count registers: reset first, then a low rdy freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign iq.IF_queue_is_full  = full;
    assign iq.ID_queue_is_empty = empty ? IQ_EMPTY : ~IQ_EMPTY;
    assign iq.ID_inst           = empty ? '0 : headEntry[ENTRY_W-1:ADDR_W];
    assign iq.ID_pc             = empty ? '0 : headEntry[ADDR_W-1:0];

endmodule

// File: tb/tb_inst_queue.sv
// Directed testbench for inst_queue.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic clk;
    logic rst;
    logic rdy;
    int   total;
    int   bad;

    inst_queue_if iq ();

    inst_queue dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .iq  (iq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iq.IF_valid  = 1'b0;
        iq.IF_inst   = '0;
        iq.IF_pc     = '0;
        iq.ID_enable = 1'b0;
        iq.ROB_clear = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rdy = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (iq.ID_queue_is_empty !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_empty got=%b want=1", iq.ID_queue_is_empty);
        end
        total++;
        if (iq.IF_queue_is_full !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_full got=%b want=0", iq.IF_queue_is_full);
        end
        total++;
        if (iq.ID_inst !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_inst got=%h want=0", iq.ID_inst);
        end
        total++;
        if (iq.ID_pc !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_pc got=%h want=0", iq.ID_pc);
        end
    endtask

    task automatic test_single();
        iq.IF_valid = 1'b1;
        iq.IF_inst  = 32'h0050_0093;
        iq.IF_pc    = 32'h0;
        tick();
        idle();
        total++;
        if (iq.ID_queue_is_empty !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_nonempty got=%b want=0", iq.ID_queue_is_empty);
        end
        total++;
        if (iq.ID_inst !== 32'h0050_0093) begin
            bad++;
            $display("[TB] FAIL single_inst got=%h want=00500093", iq.ID_inst);
        end
        total++;
        if (iq.ID_pc !== 32'h0) begin
            bad++;
            $display("[TB] FAIL single_pc got=%h want=0", iq.ID_pc);
        end
        iq.ID_enable = 1'b1;
        tick();
        total++;
        if (iq.ID_queue_is_empty !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_popped got=%b want=1", iq.ID_queue_is_empty);
        end
        // pop on empty is ignored, then push+pop on empty is push only
        tick();
        iq.IF_valid = 1'b1;
        iq.IF_inst  = 32'hAAAA_0001;
        iq.IF_pc    = 32'h0000_0100;
        tick();
        idle();
        total++;
        if (iq.ID_pc !== 32'h0000_0100) begin
            bad++;
            $display("[TB] FAIL empty_pushpop_pc got=%h want=00000100", iq.ID_pc);
        end
        total++;
        if (iq.ID_inst !== 32'hAAAA_0001) begin
            bad++;
            $display("[TB] FAIL empty_pushpop_inst got=%h want=aaaa0001", iq.ID_inst);
        end
        iq.ID_enable = 1'b1;
        tick();
        idle();
        total++;
        if (iq.ID_queue_is_empty !== 1'b1) begin
            bad++;
            $display("[TB] FAIL empty_pushpop_drain got=%b want=1", iq.ID_queue_is_empty);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            iq.IF_valid = 1'b1;
            iq.IF_inst  = 32'h1000_0000 | i;
            iq.IF_pc    = 32'(4 * i);
            tick();
            if (i == 14) begin
                total++;
                if (iq.IF_queue_is_full !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL fill_15_not_full got=%b want=0", iq.IF_queue_is_full);
                end
            end
        end
        total++;
        if (iq.IF_queue_is_full !== 1'b1) begin
            bad++;
            $display("[TB] FAIL fill_full got=%b want=1", iq.IF_queue_is_full);
        end
        iq.IF_inst = 32'hDEAD_BEEF;
        iq.IF_pc   = 32'h40;
        tick();
        idle();
        total++;
        if (iq.IF_queue_is_full !== 1'b1) begin
            bad++;
            $display("[TB] FAIL fill_drop_full got=%b want=1", iq.IF_queue_is_full);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (iq.ID_pc !== 32'(4 * i) || iq.ID_inst !== (32'h1000_0000 | i)) begin
                bad++;
                $display("[TB] FAIL fill_order[%0d] got pc=%h inst=%h want pc=%h inst=%h",
                         i, iq.ID_pc, iq.ID_inst, 32'(4 * i), 32'h1000_0000 | i);
            end
            iq.ID_enable = 1'b1;
            tick();
        end
        idle();
        total++;
        if (iq.ID_queue_is_empty !== 1'b1 || iq.IF_queue_is_full !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fill_drained got empty=%b full=%b want empty=1 full=0",
                     iq.ID_queue_is_empty, iq.IF_queue_is_full);
        end
    endtask

    task automatic test_wrap();
        int popped;
        logic sawFull;
        for (int i = 0; i < 10; i++) begin
            iq.IF_valid = 1'b1;
            iq.IF_inst  = 32'h2000_0000 | i;
            iq.IF_pc    = 32'h100 + 32'(4 * i);
            tick();
        end
        idle();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (iq.ID_pc !== 32'h100 + 32'(4 * i)) begin
                bad++;
                $display("[TB] FAIL wrap_first[%0d] got=%h want=%h",
                         i, iq.ID_pc, 32'h100 + 32'(4 * i));
            end
            iq.ID_enable = 1'b1;
            tick();
        end
        idle();
        popped  = 0;
        sawFull = 1'b0;
        for (int c = 0; c < 14; c++) begin
            iq.IF_valid  = (c < 12);
            iq.IF_inst   = 32'h3000_0000 | c;
            iq.IF_pc     = 32'h200 + 32'(4 * c);
            iq.ID_enable = (c >= 2);
            if (c >= 2) begin
                total++;
                if (iq.ID_pc !== 32'h200 + 32'(4 * popped) ||
                    iq.ID_inst !== (32'h3000_0000 | popped)) begin
                    bad++;
                    $display("[TB] FAIL wrap_overlap[%0d] got pc=%h want pc=%h",
                             popped, iq.ID_pc, 32'h200 + 32'(4 * popped));
                end
                popped++;
            end
            if (iq.IF_queue_is_full === 1'b1) sawFull = 1'b1;
            tick();
        end
        idle();
        total++;
        if (iq.ID_queue_is_empty !== 1'b1 || sawFull !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrap_end got empty=%b sawFull=%b want empty=1 sawFull=0",
                     iq.ID_queue_is_empty, sawFull);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) begin
            iq.IF_valid = 1'b1;
            iq.IF_inst  = 32'h4000_0000 | i;
            iq.IF_pc    = 32'h300 + 32'(4 * i);
            tick();
        end
        total++;
        if (iq.IF_queue_is_full !== 1'b1) begin
            bad++;
            $display("[TB] FAIL fpp_full got=%b want=1", iq.IF_queue_is_full);
        end
        iq.IF_valid  = 1'b1;
        iq.IF_inst   = 32'hBAD0_BAD0;
        iq.IF_pc     = 32'hBAD0;
        iq.ID_enable = 1'b1;
        tick();
        idle();
        total++;
        if (iq.IF_queue_is_full !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fpp_not_full got=%b want=0", iq.IF_queue_is_full);
        end
        for (int i = 1; i < 16; i++) begin
            total++;
            if (iq.ID_pc !== 32'h300 + 32'(4 * i)) begin
                bad++;
                $display("[TB] FAIL fpp_order[%0d] got=%h want=%h",
                         i, iq.ID_pc, 32'h300 + 32'(4 * i));
            end
            iq.ID_enable = 1'b1;
            tick();
        end
        idle();
        total++;
        if (iq.ID_queue_is_empty !== 1'b1) begin
            bad++;
            $display("[TB] FAIL fpp_count15 got empty=%b pc=%h want empty=1",
                     iq.ID_queue_is_empty, iq.ID_pc);
        end
    endtask

    task automatic test_clear_rdy();
        for (int i = 0; i < 8; i++) begin
            iq.IF_valid = 1'b1;
            iq.IF_inst  = 32'h5000_0000 | i;
            iq.IF_pc    = 32'h400 + 32'(4 * i);
            tick();
        end
        iq.IF_inst   = 32'h5555_5555;
        iq.IF_pc     = 32'h5555;
        iq.ID_enable = 1'b1;
        iq.ROB_clear = 1'b1;
        rdy          = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (iq.ID_pc !== 32'h400 || iq.ID_queue_is_empty !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rdy_hold[%0d] got pc=%h empty=%b want pc=00000400 empty=0",
                         i, iq.ID_pc, iq.ID_queue_is_empty);
            end
        end
        rdy = 1'b1;
        idle();
        iq.ID_enable = 1'b1;
        tick();
        idle();
        total++;
        if (iq.ID_pc !== 32'h404) begin
            bad++;
            $display("[TB] FAIL rdy_resume got=%h want=00000404", iq.ID_pc);
        end
        iq.IF_valid  = 1'b1;
        iq.IF_inst   = 32'h6666_6666;
        iq.IF_pc     = 32'h6666;
        iq.ID_enable = 1'b1;
        iq.ROB_clear = 1'b1;
        tick();
        idle();
        total++;
        if (iq.ID_queue_is_empty !== 1'b1 || iq.ID_pc !== 32'h0 || iq.ID_inst !== 32'h0) begin
            bad++;
            $display("[TB] FAIL clear_empty got empty=%b pc=%h inst=%h want empty=1 pc=0 inst=0",
                     iq.ID_queue_is_empty, iq.ID_pc, iq.ID_inst);
        end
        iq.IF_valid = 1'b1;
        iq.IF_inst  = 32'h7777_0000;
        iq.IF_pc    = 32'h700;
        tick();
        idle();
        iq.ID_enable = 1'b1;
        total++;
        if (iq.ID_pc !== 32'h700) begin
            bad++;
            $display("[TB] FAIL clear_refill got=%h want=00000700", iq.ID_pc);
        end
        tick();
        idle();
        total++;
        if (iq.ID_queue_is_empty !== 1'b1) begin
            bad++;
            $display("[TB] FAIL clear_count0 got=%b want=1", iq.ID_queue_is_empty);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rdy   = 1'b1;
        idle();
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_full_push_pop();
        test_clear_rdy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
